// File: rtl/uart_pkg.sv
// Shared UART definitions: baud codes, auto-baud FSM states, default thresholds.
package uart_pkg;

  localparam int unsigned DEF_CNT_W     = 18;
  localparam int unsigned DEF_T_19K_48K = 31250;
  localparam int unsigned DEF_T_48K_96K = 62500;
  localparam int unsigned DEF_T_96K_24K = 125000;
  localparam int unsigned DEF_MIN_SPAN  = 10416;
  localparam int unsigned DEF_MAX_SPAN  = 250000;

  // Falls counted after the start-bit fall before the 8-bit span is complete
  localparam int unsigned FCNT_W        = 3;
  localparam int unsigned FALLS_TO_LOCK = 4;

  typedef enum logic [1:0] {
    BAUD24  = 2'b00,
    BAUD48  = 2'b01,
    BAUD96  = 2'b10,
    BAUD192 = 2'b11
  } baud_e;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FALL,
    MEASURE,
    CHECK,
    LOCKED,
    ERROR
  } ab_state_e;

  // Map a measured 8-bit span onto a baud code; equality picks the slower rate
  function automatic baud_e span_to_baud(input int unsigned span,
                                         input int unsigned t_hi,
                                         input int unsigned t_mid,
                                         input int unsigned t_lo);
    baud_e code;
    if (span < t_hi)       code = BAUD192;
    else if (span < t_mid) code = BAUD96;
    else if (span < t_lo)  code = BAUD48;
    else                   code = BAUD24;
    return code;
  endfunction

endpackage

// File: rtl/uart_autobaud_ctrl_if.sv
// Auto-baud control/status bundle between the RX front end and the baud generator.
interface uart_autobaud_ctrl_if;
  import uart_pkg::*;

  logic  rx_in;
  logic  autobaud_start;
  baud_e baud_rate;
  logic  baud_en;
  logic  busy;
  logic  locked;
  logic  error;

  modport master (
    output rx_in, autobaud_start,
    input  baud_rate, baud_en, busy, locked, error
  );

  modport slave (
    input  rx_in, autobaud_start,
    output baud_rate, baud_en, busy, locked, error
  );

endinterface

// File: rtl/uart_rx_sync_edge.sv
// Two-flop synchronizer for the raw RX line with a one-cycle falling-edge pulse.
module uart_rx_sync_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic rx_async,
  output logic fall_c
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Shift the line through the synchronizer and keep one extra stage for edge detect
  always_comb begin
    sync1_d = rx_async;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Stages reset to the idle-high line level so reset never fakes a fall
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign fall_c = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: times a 0x55 sync character and locks a baud-rate code.
module uart_autobaud_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned T_19K_48K = DEF_T_19K_48K,
  parameter int unsigned T_48K_96K = DEF_T_48K_96K,
  parameter int unsigned T_96K_24K = DEF_T_96K_24K,
  parameter int unsigned MIN_SPAN  = DEF_MIN_SPAN,
  parameter int unsigned MAX_SPAN  = DEF_MAX_SPAN,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input logic                 clock,
  input logic                 reset_n,
  uart_autobaud_ctrl_if.slave ab
);

  localparam int unsigned IVAL_W     = CNT_W - 2;
  localparam int unsigned GLITCH_MIN = MIN_SPAN / 4;

  logic fall_c;

  ab_state_e          state_q, state_d;
  logic [CNT_W-1:0]   span_q, span_d;
  logic [IVAL_W-1:0]  ival_q, ival_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  baud_e              baud_rate_q, baud_rate_d;
  logic               baud_en_q, baud_en_d;
  logic               busy_q, busy_d;
  logic               locked_q, locked_d;
  logic               error_q, error_d;

  uart_rx_sync_edge u_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx_async (ab.rx_in),
    .fall_c   (fall_c)
  );

  // Next state, counters and status; a start request overrides everything else
  always_comb begin
    state_d     = state_q;
    span_d      = span_q;
    ival_d      = ival_q;
    fcnt_d      = fcnt_q;
    baud_rate_d = baud_rate_q;

    if (ab.autobaud_start) begin
      state_d = WAIT_FALL;
      span_d  = '0;
      ival_d  = '0;
      fcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        WAIT_FALL: begin
          if (fall_c) begin
            state_d = MEASURE;
            span_d  = '0;
            ival_d  = IVAL_W'(1);
            fcnt_d  = '0;
          end
        end
        MEASURE: begin
          span_d = span_q + CNT_W'(1);
          ival_d = (ival_q == '1) ? ival_q : ival_q + IVAL_W'(1);
          if (fall_c) begin
            ival_d = IVAL_W'(1);
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
          // ival_q holds the cycles since the previous fall, including this one
          if (fall_c && (ival_q < IVAL_W'(GLITCH_MIN))) begin
            state_d = ERROR;
          end else if (fall_c && (fcnt_q == FCNT_W'(FALLS_TO_LOCK - 1))) begin
            state_d = CHECK;
          end else if (span_q == CNT_W'(MAX_SPAN - 1)) begin
            state_d = ERROR;
          end
        end
        CHECK: begin
          if ((span_q < CNT_W'(MIN_SPAN)) || (span_q >= CNT_W'(MAX_SPAN))) begin
            state_d = ERROR;
          end else begin
            baud_rate_d = span_to_baud(32'(span_q), T_19K_48K, T_48K_96K, T_96K_24K);
            state_d     = LOCKED;
          end
        end
        LOCKED: ;
        ERROR: ;
        default: state_d = IDLE;
      endcase
    end

    busy_d    = (state_d == WAIT_FALL) || (state_d == MEASURE);
    locked_d  = (state_d == LOCKED);
    baud_en_d = (state_d == LOCKED);
    error_d   = (state_d == ERROR);
  end

  // State, counter and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      span_q      <= '0;
      ival_q      <= '0;
      fcnt_q      <= '0;
      baud_rate_q <= BAUD96;
      baud_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      span_q      <= span_d;
      ival_q      <= ival_d;
      fcnt_q      <= fcnt_d;
      baud_rate_q <= baud_rate_d;
      baud_en_q   <= baud_en_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
    end
  end

  assign ab.baud_rate = baud_rate_q;
  assign ab.baud_en   = baud_en_q;
  assign ab.busy      = busy_q;
  assign ab.locked    = locked_q;
  assign ab.error     = error_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Scoreboard bench for uart_autobaud_ctrl. Thresholds and bit times are scaled
// by 1/25 so every scenario stays short; their ratios are preserved.
module tb_uart_autobaud_ctrl;

  localparam int P_T1  = 1250;
  localparam int P_T2  = 2500;
  localparam int P_T3  = 5000;
  localparam int P_MIN = 416;
  localparam int P_MAX = 10000;

  typedef struct {
    bit         valid;
    bit         is_lock;
    logic [1:0] code;
    longint     cyc;
  } exp_t;

  logic   clock;
  logic   reset_n;
  longint cyc;
  int     total;
  int     bad;
  longint start_cyc;
  logic [1:0] last_code;
  exp_t   exp_q[$];
  int     seg_off[$];
  int     seg_len[$];

  // Fall offsets (after the one at 0) and low length for the boundary cases
  int bnd_off [6][4] = '{'{312, 625, 937, 1250}, '{312, 624, 936, 1249},
                         '{625, 1250, 1875, 2500}, '{624, 1249, 1874, 2499},
                         '{104, 208, 312, 416}, '{104, 208, 312, 415}};
  int bnd_len [6] = '{100, 100, 100, 100, 50, 50};
  int rate_bit [4] = '{833, 417, 208, 104};

  uart_autobaud_ctrl_if ab ();

  uart_autobaud_ctrl #(
    .T_19K_48K (P_T1),
    .T_48K_96K (P_T2),
    .T_96K_24K (P_T3),
    .MIN_SPAN  (P_MIN),
    .MAX_SPAN  (P_MAX),
    .CNT_W     (18)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ab      (ab)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [1:0] rate_code(input longint span);
    if (span < P_T1) return 2'b11;
    if (span < P_T2) return 2'b10;
    if (span < P_T3) return 2'b01;
    return 2'b00;
  endfunction

  // Reference: given the start cycle and the cycles at which rx was driven low,
  // predict the outcome. A fall reaches the FSM 3 cycles after it is driven;
  // a start reaches it 1 cycle after, and wins on a tie.
  function automatic exp_t model(input longint s, input longint f[$], input logic [1:0] prev);
    exp_t   e;
    longint g[$];
    longint span;
    e.valid = 1'b0; e.is_lock = 1'b0; e.code = prev; e.cyc = 0;
    foreach (f[i]) if (f[i] + 3 > s + 1) g.push_back(f[i]);
    if (g.size() == 0) return e;
    e.valid = 1'b1;
    for (int i = 1; i < g.size(); i++) begin
      span = g[i] - g[0];
      if (span > P_MAX || (span == P_MAX && i < 4)) begin
        e.cyc = g[0] + 3 + P_MAX;
        return e;
      end
      if (g[i] - g[i-1] < P_MIN / 4) begin
        e.cyc = g[i] + 3;
        return e;
      end
      if (i == 4) begin
        e.cyc = g[i] + 4;
        if (span >= P_MIN && span < P_MAX) begin
          e.is_lock = 1'b1;
          e.code    = rate_code(span);
        end
        return e;
      end
    end
    e.cyc = g[0] + 3 + P_MAX;
    return e;
  endfunction

  task automatic clear_segs();
    seg_off.delete();
    seg_len.delete();
  endtask

  task automatic add_seg(input int off, input int len);
    seg_off.push_back(off);
    seg_len.push_back(len);
  endtask

  task automatic build_frame(input int b);
    clear_segs();
    for (int k = 0; k < 5; k++) add_seg(2 * k * b, b);
  endtask

  task automatic pulse_start();
    ab.autobaud_start = 1'b1;
    start_cyc = cyc;
    step(1);
    ab.autobaud_start = 1'b0;
  endtask

  // Predict the segments about to be played from the current cycle
  task automatic predict_push();
    longint f[$];
    exp_t   e;
    foreach (seg_off[i]) f.push_back(cyc + longint'(seg_off[i]));
    e = model(start_cyc, f, last_code);
    if (e.valid) begin
      exp_q.push_back(e);
      last_code = e.code;
    end
  endtask

  task automatic play(input int tail);
    longint base;
    base = cyc;
    for (int i = 0; i < seg_off.size(); i++) begin
      while (cyc < base + longint'(seg_off[i])) step(1);
      ab.rx_in = 1'b0;
      while (cyc < base + longint'(seg_off[i] + seg_len[i])) step(1);
      ab.rx_in = 1'b1;
    end
    step(tail);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    chk("drain_empty", longint'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic measure(input int b);
    pulse_start();
    build_frame(b);
    predict_push();
    play(5);
    drain(P_MAX + 2000);
  endtask

  // Monitor: every rising locked/error is matched against the next expectation
  initial begin : monitor
    bit   ev;
    bit   ev_prev;
    exp_t e;
    ev_prev = 1'b0;
    forever begin
      @(negedge clock);
      ev = ab.locked | ab.error;
      if (!reset_n) begin
        ev_prev = 1'b0;
      end else begin
        if (ev && !ev_prev) begin
          chk("event_expected", longint'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ev_locked", longint'(ab.locked), longint'(e.is_lock));
            chk("ev_error", longint'(ab.error), longint'(!e.is_lock));
            chk("ev_baud_rate", longint'(ab.baud_rate), longint'(e.code));
            chk("ev_baud_en", longint'(ab.baud_en), longint'(e.is_lock));
            chk("ev_busy", longint'(ab.busy), 0);
            chk("ev_cycle", cyc, e.cyc);
          end
        end
        ev_prev = ev;
      end
    end
  end

  initial begin : stim
    int mode, b, g, k, j, s;
    total = 0; bad = 0; cyc = 0; start_cyc = 0; last_code = 2'b10;
    ab.rx_in = 1'b1;
    ab.autobaud_start = 1'b0;
    reset_n = 1'b0;
    step(3);
    chk("rst_baud_rate", longint'(ab.baud_rate), 2);
    chk("rst_baud_en", longint'(ab.baud_en), 0);
    chk("rst_busy", longint'(ab.busy), 0);
    chk("rst_locked", longint'(ab.locked), 0);
    chk("rst_error", longint'(ab.error), 0);
    reset_n = 1'b1;
    step(5);

    // Nominal rates: 9600, 2400, 19200
    measure(208);
    measure(833);
    measure(104);

    // Retrigger while locked, then 4800
    pulse_start();
    chk("retrig_locked", longint'(ab.locked), 0);
    chk("retrig_baud_en", longint'(ab.baud_en), 0);
    chk("retrig_busy", longint'(ab.busy), 1);
    chk("retrig_baud_rate", longint'(ab.baud_rate), 3);
    build_frame(417);
    predict_push();
    play(5);
    drain(P_MAX + 2000);

    // Start bit only, then idle: timeout
    pulse_start();
    clear_segs();
    add_seg(0, 208);
    predict_push();
    play(5);
    drain(P_MAX + 2000);
    chk("timeout_baud_en", longint'(ab.baud_en), 0);

    // Short low glitch 48 cycles before the b1 fall
    pulse_start();
    clear_segs();
    add_seg(0, 208);
    add_seg(2 * 208 - 48, 8);
    for (int kk = 1; kk < 5; kk++) add_seg(2 * kk * 208, 208);
    predict_push();
    play(5);
    drain(P_MAX + 2000);

    // Threshold and minimum-span boundaries
    for (int t = 0; t < 6; t++) begin
      pulse_start();
      clear_segs();
      add_seg(0, bnd_len[t]);
      for (int q = 0; q < 4; q++) add_seg(bnd_off[t][q], bnd_len[t]);
      predict_push();
      play(5);
      drain(P_MAX + 2000);
    end

    // Start coincident with a fall in MEASURE: that fall must be ignored
    pulse_start();
    ab.rx_in = 1'b0; step(208);
    ab.rx_in = 1'b1; step(208);
    ab.rx_in = 1'b0; step(2);
    pulse_start();
    step(205);
    ab.rx_in = 1'b1;
    step(300);
    chk("coinc_busy", longint'(ab.busy), 1);
    chk("coinc_locked", longint'(ab.locked), 0);
    build_frame(208);
    predict_push();
    play(5);
    drain(P_MAX + 2000);

    // Reset in the middle of a measurement
    pulse_start();
    ab.rx_in = 1'b0; step(208);
    ab.rx_in = 1'b1; step(208);
    ab.rx_in = 1'b0; step(100);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_baud_rate", longint'(ab.baud_rate), 2);
    chk("mid_rst_baud_en", longint'(ab.baud_en), 0);
    chk("mid_rst_busy", longint'(ab.busy), 0);
    chk("mid_rst_locked", longint'(ab.locked), 0);
    chk("mid_rst_error", longint'(ab.error), 0);
    step(3);
    reset_n = 1'b1;
    last_code = 2'b10;
    ab.rx_in = 1'b1;
    step(300);
    build_frame(208);
    play(5);
    step(1500);
    chk("post_rst_locked", longint'(ab.locked), 0);
    chk("post_rst_busy", longint'(ab.busy), 0);
    chk("post_rst_error", longint'(ab.error), 0);

    // Randomized: jittered nominal rates, random spans, random glitches
    for (int it = 0; it < 6; it++) begin
      step(int'($urandom_range(5, 40)));
      pulse_start();
      mode = int'($urandom_range(0, 2));
      clear_segs();
      if (mode == 0) begin
        b = rate_bit[$urandom_range(0, 3)];
        add_seg(0, b - 4);
        for (int kk = 1; kk < 5; kk++) begin
          j = int'($urandom_range(0, 6)) - 3;
          add_seg(2 * kk * b + j, b - 4);
        end
      end else if (mode == 1) begin
        s = int'($urandom_range(P_MIN, 5500));
        add_seg(0, 50);
        add_seg(s / 4, 50);
        add_seg(s / 2, 50);
        add_seg((3 * s) / 4, 50);
        add_seg(s, 50);
      end else begin
        b = 208;
        g = int'($urandom_range(10, 90));
        k = int'($urandom_range(1, 4));
        for (int kk = 0; kk < 5; kk++) begin
          if (kk == k) add_seg(2 * kk * b - g - 8, 8);
          add_seg(2 * kk * b, b);
        end
      end
      predict_push();
      play(5);
      drain(P_MAX + 2000);
    end

    step(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
